// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, register-index width and the
// memory-stage FSM state type.
package riscv_pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/Mem_wb_register.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and holds
// every data field; Mem_data only loads when mem_load_i marks returned read data.
module Mem_wb_register
    import riscv_pipe_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 bubble_i,
    input  logic                 mem_load_i,
    input  logic                 Reg_w_i,
    input  logic                 M_to_R_i,
    input  logic                 Jal_i,
    input  logic [XLEN-1:0]      Mem_data_i,
    input  logic [XLEN-1:0]      ALU_result_i,
    input  logic [XLEN-1:0]      PC_p4_i,
    input  logic [REG_IDX_W-1:0] RegD_i,
    output logic                 Reg_w_o,
    output logic                 M_to_R_o,
    output logic                 Jal_o,
    output logic [XLEN-1:0]      Mem_data_o,
    output logic [XLEN-1:0]      ALU_result_o,
    output logic [XLEN-1:0]      PC_p4_o,
    output logic [REG_IDX_W-1:0] RegD_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            Reg_w_o      <= 1'b0;
            M_to_R_o     <= 1'b0;
            Jal_o        <= 1'b0;
            Mem_data_o   <= '0;
            ALU_result_o <= '0;
            PC_p4_o      <= '0;
            RegD_o       <= '0;
        end else if (bubble_i) begin
            Reg_w_o  <= 1'b0;
            M_to_R_o <= 1'b0;
            Jal_o    <= 1'b0;
        end else begin
            Reg_w_o      <= Reg_w_i;
            M_to_R_o     <= M_to_R_i;
            Jal_o        <= Jal_i;
            ALU_result_o <= ALU_result_i;
            PC_p4_o      <= PC_p4_i;
            RegD_o       <= RegD_i;
            if (mem_load_i) begin
                Mem_data_o <= Mem_data_i;
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: data-memory handshake FSM, stall/redirect generation
// and the MEM/WB register. Define MEM_TIMEOUT_EN to abort accesses that never ack.
module memory_stage
    import riscv_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 Reg_w_i,
    input  logic                 M_to_R_i,
    input  logic                 Mem_W_i,
    input  logic                 Mem_Rd_i,
    input  logic                 Jal_i,
    input  logic                 Branch_i,
    input  logic                 Jal_Alu_i,
    input  logic [XLEN-1:0]      Inm_result_i,
    input  logic [XLEN-1:0]      PC_i,
    input  logic [XLEN-1:0]      PC_p4_i,
    input  logic [XLEN-1:0]      Reg2_i,
    input  logic [XLEN-1:0]      ALU_result_i,
    input  logic [REG_IDX_W-1:0] RegD_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    input  logic                 dmem_ack_i,
    output logic                 Stall_o,
    output logic                 PC_src_o,
    output logic [XLEN-1:0]      PC_target_o,
    output logic                 Reg_w_o,
    output logic                 M_to_R_o,
    output logic                 Jal_o,
    output logic [XLEN-1:0]      Mem_data_o,
    output logic [XLEN-1:0]      ALU_result_o,
    output logic [XLEN-1:0]      PC_p4_o,
    output logic [REG_IDX_W-1:0] RegD_o,
    output logic                 Mem_err_o,
    output mem_state_e           dbg_state_o
);

    // Handshake: dmem_req_o is high exactly while in WAIT; addr/wdata/we are
    // captured on entry and stay constant until the cycle dmem_ack_i is seen.
    mem_state_e state;
    logic       mem_access;
    logic       timeout_hit;
    logic       mem_load;
    logic       wb_bubble;

    assign mem_access  = Mem_Rd_i | Mem_W_i;
    assign dbg_state_o = state;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // An ack arriving in the same cycle as the limit still completes the access.
    assign timeout_hit = (state == WAIT) && !dmem_ack_i && (wait_cnt == 8'(TIMEOUT_CYCLES));
    assign Mem_err_o   = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign Mem_err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_access) begin
                        state        <= WAIT;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= Mem_W_i;
                        dmem_addr_o  <= ALU_result_i;
                        dmem_wdata_o <= Reg2_i;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (dmem_ack_i) begin
                        state      <= IDLE;
                        dmem_req_o <= 1'b0;
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        dmem_req_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        err_q      <= 1'b1;
`endif
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        wait_cnt   <= wait_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the combinational outputs so the whole block reads as zero at once.
    always_comb begin
        Stall_o = 1'b0;
        if (!reset_i) begin
            case (state)
                IDLE:    Stall_o = mem_access;
                WAIT:    Stall_o = !dmem_ack_i && !timeout_hit;
                default: Stall_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        PC_src_o    = 1'b0;
        PC_target_o = '0;
        if (!reset_i) begin
            if (Jal_Alu_i) begin
                PC_src_o    = 1'b1;
                PC_target_o = {ALU_result_i[XLEN-1:1], 1'b0};
            end else if (Jal_i || (Branch_i && (ALU_result_i == '0))) begin
                PC_src_o    = 1'b1;
                PC_target_o = PC_i + Inm_result_i;
            end
        end
    end

    // Stores complete with the same ack but must not disturb Mem_data.
    assign mem_load  = (state == WAIT) && dmem_ack_i && !dmem_we_o;
    assign wb_bubble = Stall_o | timeout_hit;

    Mem_wb_register u_mem_wb (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .bubble_i     (wb_bubble),
        .mem_load_i   (mem_load),
        .Reg_w_i      (Reg_w_i),
        .M_to_R_i     (M_to_R_i),
        .Jal_i        (Jal_i),
        .Mem_data_i   (dmem_rdata_i),
        .ALU_result_i (ALU_result_i),
        .PC_p4_i      (PC_p4_i),
        .RegD_i       (RegD_i),
        .Reg_w_o      (Reg_w_o),
        .M_to_R_o     (M_to_R_o),
        .Jal_o        (Jal_o),
        .Mem_data_o   (Mem_data_o),
        .ALU_result_o (ALU_result_o),
        .PC_p4_o      (PC_p4_o),
        .RegD_o       (RegD_o)
    );

endmodule
